// File: rtl/vocab_scan_ctrl.sv
// Vocabulary scan sequencer: walks an address window, reads each entry,
// and reports hit / null-entry / exhausted through a response handshake.
module vocab_scan_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned WORD_LENGTH = 3,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0]   req_word,
  input  logic [ADDR_WIDTH-1:0]               start_addr,
  input  logic [ADDR_WIDTH-1:0]               end_addr,
  output logic                                mem_en,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0]   mem_rdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic                                rsp_hit,
  output logic                                rsp_null,
  output logic [ADDR_WIDTH-1:0]               rsp_index,
  output logic [ADDR_WIDTH:0]                 rsp_count
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned WW = WORD_LENGTH * DATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] CMP  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state, nxt_state;
  logic [WW-1:0] word_q, nxt_word;
  logic [AW-1:0] end_q, nxt_end;
  logic [AW-1:0] curr_q, nxt_curr;
  logic [CW-1:0] count_q, nxt_count;
  logic          nxt_req_ready;
  logic          nxt_mem_en;
  logic [AW-1:0] nxt_mem_addr;
  logic          nxt_rsp_valid;
  logic          nxt_rsp_hit;
  logic          nxt_rsp_null;
  logic [AW-1:0] nxt_rsp_index;
  logic [CW-1:0] nxt_rsp_count;
  logic [CW-1:0] count_inc;
  logic [AW-1:0] curr_inc;

  assign count_inc = count_q + CW'(1);
  assign curr_inc  = curr_q + AW'(1);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_q    <= '0;
      end_q     <= '0;
      curr_q    <= '0;
      count_q   <= '0;
      req_ready <= 1'b1;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_null  <= 1'b0;
      rsp_index <= '0;
      rsp_count <= '0;
    end else begin
      state     <= nxt_state;
      word_q    <= nxt_word;
      end_q     <= nxt_end;
      curr_q    <= nxt_curr;
      count_q   <= nxt_count;
      req_ready <= nxt_req_ready;
      mem_en    <= nxt_mem_en;
      mem_addr  <= nxt_mem_addr;
      rsp_valid <= nxt_rsp_valid;
      rsp_hit   <= nxt_rsp_hit;
      rsp_null  <= nxt_rsp_null;
      rsp_index <= nxt_rsp_index;
      rsp_count <= nxt_rsp_count;
    end
  end

  // Next-state and next-output logic; response fields only change on RESP entry
  always_comb begin
    nxt_state     = state;
    nxt_word      = word_q;
    nxt_end       = end_q;
    nxt_curr      = curr_q;
    nxt_count     = count_q;
    nxt_mem_en    = 1'b0;
    nxt_mem_addr  = mem_addr;
    nxt_rsp_valid = rsp_valid;
    nxt_rsp_hit   = rsp_hit;
    nxt_rsp_null  = rsp_null;
    nxt_rsp_index = rsp_index;
    nxt_rsp_count = rsp_count;

    case (state)
      IDLE: begin
        if (req_valid) begin
          nxt_word  = req_word;
          nxt_end   = end_addr;
          nxt_curr  = start_addr;
          nxt_count = '0;
          if (req_word == '0) begin
            nxt_state     = RESP;
            nxt_rsp_valid = 1'b1;
            nxt_rsp_hit   = 1'b0;
            nxt_rsp_null  = 1'b0;
            nxt_rsp_index = start_addr;
            nxt_rsp_count = '0;
          end else begin
            nxt_state    = READ;
            nxt_mem_en   = 1'b1;
            nxt_mem_addr = start_addr;
          end
        end
      end
      READ: begin
        nxt_state = CMP;
      end
      CMP: begin
        nxt_count = count_inc;
        if (mem_rdata == word_q || mem_rdata == '0 || curr_q == end_q) begin
          nxt_state     = RESP;
          nxt_rsp_valid = 1'b1;
          nxt_rsp_hit   = (mem_rdata == word_q);
          nxt_rsp_null  = (mem_rdata != word_q) && (mem_rdata == '0);
          nxt_rsp_index = curr_q;
          nxt_rsp_count = count_inc;
        end else begin
          nxt_state    = READ;
          nxt_curr     = curr_inc;
          nxt_mem_en   = 1'b1;
          nxt_mem_addr = curr_inc;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          nxt_state     = IDLE;
          nxt_rsp_valid = 1'b0;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    nxt_req_ready = (nxt_state == IDLE);
  end

endmodule
